tx_pdu_scheduler: RTL and testbench

Sequences the TX PDU/CRC generator and shares it between N_REQ packet requesters (e.g. advertising queue, data-channel queue). It picks a requester round-robin and latches that requester's pdu_type, crc_init and packet_hdr into the generator. It then fires the generator restart, routes the granted requester's payload stream, and waits for end-of-packet or timeout. After each packet it enforces an inter-frame gap and reports completion status.

---
 rtl/tx_pdu_scheduler.sv | 159 +++++++++++++++
 tb/tb_tx_pdu_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pdu_scheduler.sv
// Shares one TX PDU/CRC generator among N_REQ requesters: round-robin pick, config latch, restart, end/timeout wait, inter-frame gap.
// Latency: request sampled in IDLE -> req_ready +2 cycles -> gen_restart +3 cycles; done_valid in the same cycle as gen_event_end/timeout.
// Backpressure: requesters hold req_valid and data until their one-hot req_ready; no arbitration while busy or while enable is low.
module tx_pdu_scheduler #(
    parameter int N_REQ          = 2,
    parameter int PDU_TYPE_W     = 2,
    parameter int IFS_CYCLES     = 150,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          enable,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*PDU_TYPE_W-1:0]   req_pdu_type,
    input  logic [N_REQ*24-1:0]           req_crc_init,
    input  logic [N_REQ*24-1:0]           req_packet_hdr,
    output logic                          gen_restart,
    output logic [PDU_TYPE_W-1:0]         gen_pdu_type,
    output logic [23:0]                   gen_crc_init,
    output logic [23:0]                   gen_packet_hdr,
    input  logic                          gen_event_payload,
    input  logic                          gen_event_end,
    output logic [N_REQ-1:0]              payload_grant,
    output logic                          busy,
    output logic                          done_valid,
    output logic [$clog2(N_REQ)-1:0]      done_id,
    output logic [1:0]                    done_status
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int IFS_W = (IFS_CYCLES > 2) ? $clog2(IFS_CYCLES) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IFS_W-1:0] IFS_LAST = IFS_W'((IFS_CYCLES > 0) ? IFS_CYCLES - 1 : 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARB    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_ACTIVE = 3'd4;
    localparam logic [2:0] S_IFS    = 3'd5;

    // Generator configuration captured from the granted requester.
    typedef struct packed {
        logic [PDU_TYPE_W-1:0] pdu_type;
        logic [23:0]           crc_init;
        logic [23:0]           packet_hdr;
    } cfg_t;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_ptr;
    cfg_t             cfg_q;
    logic             seen_payload;
    logic [TO_W-1:0]  to_cnt;
    logic [IFS_W-1:0] ifs_cnt;

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [N_REQ-1:0] grant_onehot;
    logic             in_active;
    logic             to_hit;
    logic             pkt_fin;

    assign grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
    assign in_active    = (state == S_ACTIVE);
    assign to_hit       = (to_cnt == TO_LAST);
    // End-of-packet wins over a coincident timeout; only the status bit differs.
    assign pkt_fin      = in_active & (gen_event_end | to_hit);

    // Round-robin pick: lowest offset from the pointer wins, so scan offsets high to low.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    // Next-state selection for the packet sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (enable && (|req_valid)) state_nxt = S_ARB;
            S_ARB:    state_nxt = arb_found ? S_LOAD : S_IDLE;
            S_LOAD:   state_nxt = S_START;
            S_START:  state_nxt = S_ACTIVE;
            S_ACTIVE: if (pkt_fin) state_nxt = (IFS_CYCLES == 0) ? S_IDLE : S_IFS;
            S_IFS:    if (ifs_cnt == '0) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register plus grant, config, pointer and counter updates per state.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= S_IDLE;
            grant_idx     <= '0;
            rr_ptr        <= '0;
            cfg_q         <= '0;
            payload_grant <= '0;
            seen_payload  <= 1'b0;
            to_cnt        <= '0;
            ifs_cnt       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_ARB: begin
                    if (arb_found) grant_idx <= arb_idx;
                end
                S_LOAD: begin
                    cfg_q.pdu_type   <= req_pdu_type[grant_idx*PDU_TYPE_W +: PDU_TYPE_W];
                    cfg_q.crc_init   <= req_crc_init[grant_idx*24 +: 24];
                    cfg_q.packet_hdr <= req_packet_hdr[grant_idx*24 +: 24];
                    payload_grant    <= grant_onehot;
                    if (grant_idx == IDX_W'(N_REQ - 1)) rr_ptr <= '0;
                    else                                 rr_ptr <= grant_idx + 1'b1;
                end
                S_START: begin
                    to_cnt       <= '0;
                    seen_payload <= 1'b0;
                end
                S_ACTIVE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (gen_event_payload) seen_payload <= 1'b1;
                    if (pkt_fin) begin
                        payload_grant <= '0;
                        ifs_cnt       <= IFS_LAST;
                    end
                end
                S_IFS: begin
                    if (ifs_cnt != '0) ifs_cnt <= ifs_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Handshake, restart and completion outputs decoded from state; completion includes the same-cycle events.
    always_comb begin
        req_ready   = (state == S_LOAD) ? grant_onehot : '0;
        gen_restart = (state == S_START);
        busy        = (state != S_IDLE);
        done_valid  = pkt_fin;
        done_id     = pkt_fin ? grant_idx : '0;
        done_status = pkt_fin ? {seen_payload | gen_event_payload, ~gen_event_end} : 2'b00;
    end

    assign gen_pdu_type   = cfg_q.pdu_type;
    assign gen_crc_init   = cfg_q.crc_init;
    assign gen_packet_hdr = cfg_q.packet_hdr;

endmodule

// File: tb/tb_tx_pdu_scheduler.sv
// Bench for tx_pdu_scheduler with N_REQ=2, IFS_CYCLES=150, TIMEOUT_CYCLES=16.
// Grants and completions are queued as expectations when a packet is planned and popped by a monitor.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_tx_pdu_scheduler;

    localparam int NR  = 2;
    localparam int PW  = 2;
    localparam int IFS = 150;
    localparam int TO  = 16;

    logic           aclk;
    logic           areset;
    logic           enable;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [NR*PW-1:0] req_pdu_type;
    logic [NR*24-1:0] req_crc_init;
    logic [NR*24-1:0] req_packet_hdr;
    logic           gen_restart;
    logic [PW-1:0]  gen_pdu_type;
    logic [23:0]    gen_crc_init;
    logic [23:0]    gen_packet_hdr;
    logic           gen_event_payload;
    logic           gen_event_end;
    logic [NR-1:0]  payload_grant;
    logic           busy;
    logic           done_valid;
    logic [0:0]     done_id;
    logic [1:0]     done_status;

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0]   crc_tab [NR];
    logic [23:0]   hdr_tab [NR];
    logic [PW-1:0] pdu_tab [NR];

    int          exp_grant[$];
    logic [2:0]  exp_done[$];   // {status, id}

    tx_pdu_scheduler #(
        .N_REQ(NR), .PDU_TYPE_W(PW), .IFS_CYCLES(IFS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk(aclk), .areset(areset), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pdu_type(req_pdu_type), .req_crc_init(req_crc_init), .req_packet_hdr(req_packet_hdr),
        .gen_restart(gen_restart), .gen_pdu_type(gen_pdu_type),
        .gen_crc_init(gen_crc_init), .gen_packet_hdr(gen_packet_hdr),
        .gen_event_payload(gen_event_payload), .gen_event_end(gen_event_end),
        .payload_grant(payload_grant), .busy(busy),
        .done_valid(done_valid), .done_id(done_id), .done_status(done_status)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard side: every accept pulse and every completion must match the next queued expectation.
    always @(negedge aclk) begin
        if (|req_ready) begin
            if (exp_grant.size() == 0) check("grant_unexp", req_ready, 0);
            else check("grant_order", req_ready, 64'(1) << exp_grant.pop_front());
        end
        if (done_valid) begin
            if (exp_done.size() == 0) check("done_unexp", done_valid, 0);
            else begin
                logic [2:0] e;
                e = exp_done.pop_front();
                check("done_id", done_id, e[0]);
                check("done_status", done_status, e[2:1]);
            end
        end
    end

    // Called at the falling edge of the cycle in which IDLE samples the request.
    task automatic do_packet(input int id, input int pay_at, input int end_at,
                             input logic [NR-1:0] next_valid, input logic next_en);
        int n;
        int done_k;
        logic seen;
        logic [1:0] st;
        done_k = (end_at >= 0 && end_at < TO) ? end_at : TO - 1;
        seen   = (pay_at >= 0 && pay_at <= done_k);
        st     = {seen, (end_at != done_k)};
        exp_grant.push_back(id);
        exp_done.push_back({st, id[0]});
        n = 0;
        do begin
            tick();
            @(negedge aclk);
            n++;
        end while (req_ready == '0 && n < 400);
        check("ready_latency", n, 2);
        if (req_ready == '0) return;
        tick();
        req_valid = next_valid;
        enable    = next_en;
        @(negedge aclk);
        check("restart", gen_restart, 1);
        check("cfg_crc", gen_crc_init, crc_tab[id]);
        check("cfg_hdr", gen_packet_hdr, hdr_tab[id]);
        check("cfg_pdu", gen_pdu_type, pdu_tab[id]);
        check("pgrant_start", payload_grant, 64'(1) << id);
        for (int k = 0; k <= done_k; k++) begin
            tick();
            gen_event_payload = (k == pay_at);
            gen_event_end     = (k == end_at);
            @(negedge aclk);
            check("done_timing", done_valid, (k == done_k));
        end
        check("pgrant_last", payload_grant, 64'(1) << id);
        for (int i = 1; i <= IFS + 1; i++) begin
            tick();
            gen_event_payload = 1'b0;
            gen_event_end     = 1'b0;
            @(negedge aclk);
            if (i == 1)       check("pgrant_clr", payload_grant, 0);
            if (i == IFS)     check("ifs_busy", busy, 1);
            if (i == IFS + 1) check("ifs_idle", busy, 0);
        end
    endtask

    initial begin
        logic any_act;
        crc_tab[0] = 24'h555555; hdr_tab[0] = 24'h000A00; pdu_tab[0] = 2'd2;
        crc_tab[1] = 24'hABCDEF; hdr_tab[1] = 24'h001400; pdu_tab[1] = 2'd1;
        req_crc_init      = {crc_tab[1], crc_tab[0]};
        req_packet_hdr    = {hdr_tab[1], hdr_tab[0]};
        req_pdu_type      = {pdu_tab[1], pdu_tab[0]};
        areset            = 1'b1;
        enable            = 1'b0;
        req_valid         = '0;
        gen_event_payload = 1'b0;
        gen_event_end     = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_outputs", {busy, done_valid, gen_restart, req_ready, payload_grant, done_status,
                              done_id, gen_pdu_type, gen_crc_init, gen_packet_hdr}, 0);
        tick();
        areset = 1'b0;
        @(negedge aclk);
        check("idle_busy", busy, 0);

        // Single packet from requester 0 with a payload pulse.
        tick();
        req_valid = 2'b01;
        enable    = 1'b1;
        @(negedge aclk);
        check("ready_c0", req_ready, 0);
        do_packet(0, 2, 6, 2'b00, 1'b1);

        // Round-robin from a fresh pointer with both requesters held valid.
        tick();
        areset = 1'b1;
        tick();
        areset    = 1'b0;
        req_valid = 2'b11;
        @(negedge aclk);
        do_packet(0, 1, 3, 2'b11, 1'b1);
        do_packet(1, -1, 5, 2'b11, 1'b1);
        do_packet(0, 0, 2, 2'b11, 1'b1);
        do_packet(1, 4, 7, 2'b00, 1'b1);

        // Timeout, then the pointer must have moved on to requester 1.
        tick();
        req_valid = 2'b01;
        @(negedge aclk);
        do_packet(0, 3, -1, 2'b11, 1'b1);
        // End and timeout in the same cycle count as success.
        do_packet(1, -1, TO - 1, 2'b00, 1'b1);

        // enable dropped mid-packet: packet completes, then no new accept until re-enabled.
        tick();
        req_valid = 2'b01;
        @(negedge aclk);
        do_packet(0, 2, 8, 2'b01, 1'b0);
        any_act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge aclk);
            any_act = any_act | busy | (|req_ready);
        end
        check("enable_hold", any_act, 0);
        tick();
        enable = 1'b1;
        @(negedge aclk);
        do_packet(0, -1, 1, 2'b00, 1'b1);

        // Reset in ACTIVE: outputs clear at once, no completion, arbitration restarts at requester 0.
        tick();
        req_valid = 2'b11;
        exp_grant.push_back(1);
        @(negedge aclk);
        tick(); @(negedge aclk);
        tick(); @(negedge aclk);
        check("rst_t_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        @(negedge aclk);
        tick(); @(negedge aclk);
        tick(); @(negedge aclk);
        check("rst_t_active", busy, 1);
        tick();
        areset            = 1'b1;
        gen_event_end     = 1'b1;
        gen_event_payload = 1'b1;
        #1;
        check("rst_mid_outputs", {busy, done_valid, gen_restart, req_ready, payload_grant, done_status,
                                  done_id, gen_pdu_type, gen_crc_init, gen_packet_hdr}, 0);
        @(negedge aclk);
        check("rst_mid_done", done_valid, 0);
        tick();
        tick();
        areset            = 1'b0;
        gen_event_end     = 1'b0;
        gen_event_payload = 1'b0;
        req_valid         = 2'b11;
        @(negedge aclk);
        do_packet(0, -1, 4, 2'b00, 1'b1);

        check("grant_q_drained", exp_grant.size(), 0);
        check("done_q_drained", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
